// File: rtl/hsv_ctrl_scheduler_pkg.sv
// Shared definitions for the HSV saturation/value control scheduler.
//   - state_t      : scheduler FSM encoding (IDLE / APPLY / SETTLE)
//   - CTRL_W       : width of the sign-magnitude control word
//   - MAG_MAX_DEF  : default largest gain magnitude in percent
//   - gain_encode  : 9-bit sign-magnitude host word -> clamped signed value
//   - gain_decode  : signed value -> 9-bit sign-magnitude control word
package hsv_ctrl_pkg;

  localparam int unsigned CTRL_W      = 9;
  localparam int unsigned MAG_MAX_DEF = 100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Bit 8 of the host word is ignored. A "negative zero" write encodes to
  // plain zero, so the datapath never sees a set sign bit with zero magnitude.
  function automatic logic signed [7:0] gain_encode(input logic [CTRL_W-1:0] data,
                                                    input logic [6:0]        mag_lim);
    logic [6:0] mag;
    logic signed [7:0] val;
    mag = (data[6:0] > mag_lim) ? mag_lim : data[6:0];
    val = $signed({1'b0, mag});
    return data[7] ? -val : val;
  endfunction

  function automatic logic [CTRL_W-1:0] gain_decode(input logic signed [7:0] val);
    logic [7:0] mag;
    mag = (val < 0) ? -val : val;
    return {1'b0, val[7], mag[6:0]};
  endfunction

endpackage

// File: rtl/hsv_ctrl_scheduler_if.sv
// Host configuration write channel of the HSV control scheduler.
//   cfg_valid : host write request
//   cfg_ready : scheduler can accept a write (only while idle)
//   cfg_sel   : 0 = saturation target, 1 = value target
//   cfg_data  : sign-magnitude gain, [7] subtract, [6:0] magnitude, [8] ignored
// master = host side, slave = scheduler side.
interface hsv_ctrl_scheduler_if;
  import hsv_ctrl_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_sel;
  logic [CTRL_W-1:0] cfg_data;

  modport master (output cfg_valid, output cfg_sel, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_sel, input cfg_data, output cfg_ready);

endinterface

// File: rtl/hsv_ctrl_scheduler_gain_ramp.sv
// One gain channel (S or V) of the HSV control scheduler.
// Holds the host target and the gain currently presented to the datapath.
// On apply the current gain either jumps to the target or moves toward it
// by at most ramp_step (0 behaves as 1).
//   clk, rst    : clock, synchronous active-high reset
//   wr_en       : load target from wr_data
//   wr_data     : sign-magnitude host word
//   apply       : frame-start update strobe from the scheduler FSM
//   ramp_en     : 1 = bounded step, 0 = jump
//   ramp_step   : per-frame magnitude limit
//   ctrl        : sign-magnitude gain to the datapath
//   at_target   : current gain equals target
module hsv_gain_ramp
  import hsv_ctrl_pkg::*;
#(
  parameter int unsigned MAG_MAX = MAG_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CTRL_W-1:0] wr_data,
  input  logic              apply,
  input  logic              ramp_en,
  input  logic [6:0]        ramp_step,
  output logic [CTRL_W-1:0] ctrl,
  output logic              at_target
);

  localparam logic [6:0] MAG_LIM = 7'(MAG_MAX);

  logic signed [7:0] cur_q;
  logic signed [7:0] tgt_q;
  logic signed [7:0] cur_d;
  logic signed [8:0] lim;
  logic signed [8:0] diff;
  logic signed [8:0] step;
  logic signed [8:0] sum;

  function automatic logic signed [8:0] step_clamp(input logic signed [8:0] d,
                                                   input logic signed [8:0] l);
    logic signed [8:0] r;
    r = d;
    if (d > l)
      r = l;
    else if (d < -l)
      r = -l;
    return r;
  endfunction

  // Differences span -200..+200, so 9-bit signed arithmetic is exact. The
  // clamped step never overshoots the target, so the sum fits back in 8 bits.
  always_comb begin
    lim   = $signed({2'b00, (ramp_step == 7'd0) ? 7'd1 : ramp_step});
    diff  = $signed({tgt_q[7], tgt_q}) - $signed({cur_q[7], cur_q});
    step  = step_clamp(diff, lim);
    sum   = $signed({cur_q[7], cur_q}) + step;
    cur_d = ramp_en ? sum[7:0] : tgt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= '0;
      tgt_q <= '0;
    end else begin
      if (wr_en)
        tgt_q <= gain_encode(wr_data, MAG_LIM);
      if (apply)
        cur_q <= cur_d;
    end
  end

  assign ctrl      = gain_decode(cur_q);
  assign at_target = (cur_q == tgt_q);

endmodule

// File: rtl/hsv_ctrl_scheduler.sv
// HSV saturation/value adjust control scheduler.
// Host gain writes are captured at any idle time but applied to control_S /
// control_V only at frame start, followed by a guard of PIPE_LAT clocks while
// the adjust pipeline drains; frame starts inside that window are dropped.
//   clk, rst     : pixel clock, synchronous active-high reset
//   frame_start  : one-cycle pulse at start of vertical blanking
//   cfg          : host write channel (slave side)
//   ramp_en      : 1 = step toward target per frame, 0 = jump
//   ramp_step    : max magnitude change per frame when ramping
//   control_S/V  : sign-magnitude gains to the datapath
//   busy         : applying or settling
//   settled      : both gains equal their targets
module hsv_ctrl_scheduler
  import hsv_ctrl_pkg::*;
#(
  parameter int unsigned MAG_MAX  = MAG_MAX_DEF,
  parameter int unsigned PIPE_LAT = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  hsv_ctrl_scheduler_if.slave  cfg,
  input  logic                 ramp_en,
  input  logic [6:0]           ramp_step,
  output logic [CTRL_W-1:0]    control_S,
  output logic [CTRL_W-1:0]    control_V,
  output logic                 busy,
  output logic                 settled
);

  localparam int unsigned CNT_W = $clog2(PIPE_LAT) + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             apply;
  logic             wr_acc;
  logic             at_s, at_v;

  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign wr_acc        = cfg.cfg_valid & cfg.cfg_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    apply   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start)
          state_d = ST_APPLY;
      end
      ST_APPLY: begin
        apply   = 1'b1;
        state_d = ST_SETTLE;
        cnt_d   = CNT_W'(PIPE_LAT - 1);
      end
      ST_SETTLE: begin
        if (cnt_q == '0)
          state_d = ST_IDLE;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      settled <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      settled <= at_s & at_v;
    end
  end

  hsv_gain_ramp #(.MAG_MAX(MAG_MAX)) u_ramp_s (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_acc & ~cfg.cfg_sel),
    .wr_data   (cfg.cfg_data),
    .apply     (apply),
    .ramp_en   (ramp_en),
    .ramp_step (ramp_step),
    .ctrl      (control_S),
    .at_target (at_s)
  );

  hsv_gain_ramp #(.MAG_MAX(MAG_MAX)) u_ramp_v (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_acc & cfg.cfg_sel),
    .wr_data   (cfg.cfg_data),
    .apply     (apply),
    .ramp_en   (ramp_en),
    .ramp_step (ramp_step),
    .ctrl      (control_V),
    .at_target (at_v)
  );

endmodule
